color_to_grayscale_stream: RTL

//  Streaming multi-lane RGB -> grayscale converter with valid/ready handshake.
//  - Converts LANES pixels per beat through a 2-stage pipeline with backpressure.
//  - Tracks row boundaries: flags end-of-row and row-length errors.
//  - Sits between the pixel source (frame reader) and downstream grayscale filters.

---
 rtl/color_to_grayscale_pkg.sv | 18 +
 rtl/color_to_grayscale_stream_gray_lane.sv | 65 ++++++
 rtl/color_to_grayscale_stream.sv | 103 ++++++++++
 3 files changed

// File: rtl/color_to_grayscale_pkg.sv
// Shared constants and types for the RGB -> grayscale stream.
package color_to_grayscale_pkg;

    localparam int COEF_R     = 77;
    localparam int COEF_G     = 150;
    localparam int COEF_B     = 29;
    localparam int COEF_SHIFT = 8;
    localparam int ROUND      = 128;

    // Average mode reuses the weighted-sum datapath: 64R+128G+64B, +128, >>8
    // is exactly (R + 2G + B + 2) >> 2.
    localparam int AVG_R      = 64;
    localparam int AVG_G      = 128;
    localparam int AVG_B      = 64;

    typedef enum logic {GRAY_BT601, GRAY_AVG} gray_mode_e;

endpackage

// File: rtl/color_to_grayscale_stream_gray_lane.sv
// One lane of the grayscale converter: stage 1 registers the three weighted
// products, stage 2 registers the rounded sum. Both stages advance on i_en.
module gray_lane
    import color_to_grayscale_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic [PIX_W-1:0] i_r,
    input  logic [PIX_W-1:0] i_g,
    input  logic [PIX_W-1:0] i_b,
    output logic [PIX_W-1:0] o_gray
);

    localparam int PW = PIX_W + 8;
    localparam int SW = PIX_W + 9;

    gray_mode_e    w_mode;
    logic [7:0]    w_cr, w_cg, w_cb;
    logic [SW-1:0] w_sum;

    logic [PW-1:0]    r_pr, r_pg, r_pb;
    logic [PIX_W-1:0] r_gray;

    assign w_mode = gray_mode_e'(i_mode);

    always_comb begin
        w_cr = 8'(COEF_R);
        w_cg = 8'(COEF_G);
        w_cb = 8'(COEF_B);
        if (w_mode == GRAY_AVG) begin
            w_cr = 8'(AVG_R);
            w_cg = 8'(AVG_G);
            w_cb = 8'(AVG_B);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pr <= '0;
            r_pg <= '0;
            r_pb <= '0;
        end else if (i_en) begin
            r_pr <= PW'(i_r) * PW'(w_cr);
            r_pg <= PW'(i_g) * PW'(w_cg);
            r_pb <= PW'(i_b) * PW'(w_cb);
        end
    end

    // Weights sum to 256, so the shifted result always fits in PIX_W bits.
    assign w_sum = SW'(r_pr) + SW'(r_pg) + SW'(r_pb) + SW'(ROUND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_gray <= '0;
        else if (i_en)
            r_gray <= PIX_W'(w_sum >> COEF_SHIFT);
    end

    assign o_gray = r_gray;

endmodule

// File: rtl/color_to_grayscale_stream.sv
// Multi-lane RGB -> grayscale stream: handshake, valid/eol pipeline, row
// beat counter and sticky row error. Optional `GRAY_MODE_SEL_EN adds in_mode.
module color_to_grayscale_stream
    import color_to_grayscale_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int LANES   = 4,
    parameter int ROW_LEN = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sol,
    input  logic [LANES*PIX_W-1:0] in_r,
    input  logic [LANES*PIX_W-1:0] in_g,
    input  logic [LANES*PIX_W-1:0] in_b,
`ifdef GRAY_MODE_SEL_EN
    input  logic                   in_mode,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*PIX_W-1:0] out_gray,
    output logic                   out_eol,
    output logic                   row_err
);

    localparam int BEATS = ROW_LEN / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if ((ROW_LEN % LANES) != 0 || ROW_LEN < LANES) begin : g_bad_row_len
            $error("ROW_LEN must be a non-zero multiple of LANES");
        end
    endgenerate

    logic          w_en, w_acc, w_last, w_mode;
    logic [CW-1:0] w_idx;

    logic          r_v1, r_eol1, r_out_valid, r_out_eol, r_row_err;
    logic [CW-1:0] r_cnt;

    // Pipeline advances when the output slot is empty or being consumed.
    assign w_en     = out_ready | ~r_out_valid;
    assign in_ready = w_en;
    assign w_acc    = in_valid & w_en;

`ifdef GRAY_MODE_SEL_EN
    assign w_mode = in_mode;
`else
    assign w_mode = GRAY_BT601;
`endif

    // A start-of-line beat is always beat 0, even if it truncates a row.
    assign w_idx  = in_sol ? '0 : r_cnt;
    assign w_last = (w_idx == CW'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_row_err <= 1'b0;
        end else if (w_acc) begin
            r_cnt <= w_last ? '0 : w_idx + CW'(1);
            if (in_sol && r_cnt != '0)
                r_row_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_eol1      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_eol   <= 1'b0;
        end else if (w_en) begin
            r_v1        <= in_valid;
            r_eol1      <= in_valid & w_last;
            r_out_valid <= r_v1;
            r_out_eol   <= r_eol1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            gray_lane #(.PIX_W(PIX_W)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .i_en   (w_en),
                .i_mode (w_mode),
                .i_r    (in_r[k*PIX_W +: PIX_W]),
                .i_g    (in_g[k*PIX_W +: PIX_W]),
                .i_b    (in_b[k*PIX_W +: PIX_W]),
                .o_gray (out_gray[k*PIX_W +: PIX_W])
            );
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign out_eol   = r_out_eol;
    assign row_err   = r_row_err;

endmodule
